// File: rtl/wb_regfile_pkg.sv
// Shared types and constants for the writeback stage: exception bus width,
// the hard-wired zero register and the trace entry layout.
package wb_regfile_pkg;

   localparam int         EXCEPT_W     = 32;
   localparam logic [4:0] REG_ZERO     = 5'd0;
   localparam logic [3:0] TRACE_WEN_ON = 4'hf;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  wnum;
      logic [31:0] wdata;
   } trace_entry_t;

endpackage

// File: rtl/wb_trace_fifo.sv
// Two-write / one-read trace FIFO. The head entry is presented while the FIFO is non-empty
// and is popped on every such cycle. The stall flag is raised one cycle ahead of running out of room.
module wb_trace_fifo
   import wb_regfile_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push0,
   input  trace_entry_t i_entry0,
   input  logic         i_push1,
   input  trace_entry_t i_entry1,
   output logic         o_valid,
   output trace_entry_t o_head,
   output logic         o_stall
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   trace_entry_t   r_mem [DEPTH];
   logic [PW-1:0]  r_wptr;
   logic [PW-1:0]  r_rptr;
   logic [CW-1:0]  r_count;
   logic           r_stall;

   logic           w_pop;
   logic           w_drop;
   logic [CW-1:0]  w_req;
   logic [CW-1:0]  w_avail;
   logic [CW-1:0]  w_acc;
   logic [CW-1:0]  w_count_next;
   trace_entry_t   w_first;

   // The slot being popped this cycle can be refilled on the same edge.
   always_comb begin
      w_pop        = (r_count != '0);
      w_req        = CW'(i_push0) + CW'(i_push1);
      w_avail      = CW'(DEPTH) - r_count + CW'(w_pop);
      w_drop       = (w_req > w_avail);
      w_acc        = w_drop ? w_avail : w_req;
      w_count_next = r_count - CW'(w_pop) + w_acc;
      w_first      = i_push0 ? i_entry0 : i_entry1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_acc >= CW'(1))
            r_mem[r_wptr] <= w_first;
         if (w_acc == CW'(2))
            r_mem[r_wptr + PW'(1)] <= i_entry1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_stall <= 1'b0;
      end else begin
         r_wptr  <= r_wptr + w_acc[PW-1:0];
         if (w_pop)
            r_rptr <= r_rptr + PW'(1);
         r_count <= w_count_next;
         r_stall <= (w_count_next > CW'(DEPTH - 2));
      end
   end

   assign o_valid = w_pop;
   assign o_head  = w_pop ? r_mem[r_rptr] : '0;
   assign o_stall = r_stall;

   // Upstream must honour o_stall; an entry arriving with no room is lost.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !w_drop);

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: 32x32 GPR file with same-cycle bypass, HI/LO register,
// and a program-ordered retirement trace serialised through wb_trace_fifo.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int TRACE_DEPTH = 4
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                W_master_hilowrite,
   input  logic                W_master_reg_wen,
   input  logic                W_master_memtoReg,
   input  logic [4:0]          W_master_reg_waddr,
   input  logic [EXCEPT_W-1:0] W_master_except,
   input  logic [31:0]         W_master_pc,
   input  logic [31:0]         W_master_alu_res,
   input  logic [31:0]         W_master_mem_rdata,
   input  logic [63:0]         W_master_alu_out64,
   input  logic                W_slave_reg_wen,
   input  logic [4:0]          W_slave_reg_waddr,
   input  logic [EXCEPT_W-1:0] W_slave_except,
   input  logic [31:0]         W_slave_pc,
   input  logic [31:0]         W_slave_alu_res,
   input  logic [4:0]          raddr0,
   input  logic [4:0]          raddr1,
   input  logic [4:0]          raddr2,
   input  logic [4:0]          raddr3,
   output logic [31:0]         rdata0,
   output logic [31:0]         rdata1,
   output logic [31:0]         rdata2,
   output logic [31:0]         rdata3,
   output logic [31:0]         hi_o,
   output logic [31:0]         lo_o,
   output logic                trace_stall,
   output logic [31:0]         debug_wb_pc,
   output logic [3:0]          debug_wb_rf_wen,
   output logic [4:0]          debug_wb_rf_wnum,
   output logic [31:0]         debug_wb_rf_wdata
);

   logic [31:0]  r_gpr [32];
   logic [63:0]  r_hilo;

   logic         w_m_commit;
   logic         w_s_commit;
   logic         w_hilo_we;
   logic [31:0]  w_m_wdata;
   logic [63:0]  w_hilo;
   logic [4:0]   w_raddr [4];
   logic [31:0]  w_rdata [4];
   trace_entry_t w_m_entry;
   trace_entry_t w_s_entry;
   trace_entry_t w_head;
   logic         w_head_valid;

   assign w_m_wdata  = W_master_memtoReg ? W_master_mem_rdata : W_master_alu_res;
   assign w_m_commit = W_master_reg_wen & (W_master_reg_waddr != REG_ZERO)
                     & (W_master_except == '0);
   // The slave is the younger instruction, so a master exception squashes it too.
   assign w_s_commit = W_slave_reg_wen & (W_slave_reg_waddr != REG_ZERO)
                     & (W_slave_except == '0) & (W_master_except == '0);
   assign w_hilo_we  = W_master_hilowrite & (W_master_except == '0);

   assign w_raddr[0] = raddr0;
   assign w_raddr[1] = raddr1;
   assign w_raddr[2] = raddr2;
   assign w_raddr[3] = raddr3;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_rdata[i] = r_gpr[w_raddr[i]];
         if (w_raddr[i] == REG_ZERO)
            w_rdata[i] = '0;
         else if (w_s_commit && (w_raddr[i] == W_slave_reg_waddr))
            w_rdata[i] = W_slave_alu_res;
         else if (w_m_commit && (w_raddr[i] == W_master_reg_waddr))
            w_rdata[i] = w_m_wdata;
      end
   end

   assign rdata0 = w_rdata[0];
   assign rdata1 = w_rdata[1];
   assign rdata2 = w_rdata[2];
   assign rdata3 = w_rdata[3];

   assign w_hilo = w_hilo_we ? W_master_alu_out64 : r_hilo;
   assign hi_o   = w_hilo[63:32];
   assign lo_o   = w_hilo[31:0];

   // Slave write is issued last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++)
            r_gpr[i] <= '0;
         r_hilo <= '0;
      end else begin
         if (w_m_commit)
            r_gpr[W_master_reg_waddr] <= w_m_wdata;
         if (w_s_commit)
            r_gpr[W_slave_reg_waddr] <= W_slave_alu_res;
         if (w_hilo_we)
            r_hilo <= W_master_alu_out64;
      end
   end

   assign w_m_entry = '{pc: W_master_pc, wnum: W_master_reg_waddr, wdata: w_m_wdata};
   assign w_s_entry = '{pc: W_slave_pc, wnum: W_slave_reg_waddr, wdata: W_slave_alu_res};

   wb_trace_fifo #(
      .DEPTH    (TRACE_DEPTH)
   ) u_trace_fifo (
      .clk      (clk),
      .rst      (rst),
      .i_push0  (w_m_commit & (W_master_pc != '0)),
      .i_entry0 (w_m_entry),
      .i_push1  (w_s_commit & (W_slave_pc != '0)),
      .i_entry1 (w_s_entry),
      .o_valid  (w_head_valid),
      .o_head   (w_head),
      .o_stall  (trace_stall)
   );

   assign debug_wb_rf_wen   = w_head_valid ? TRACE_WEN_ON : 4'h0;
   assign debug_wb_pc       = w_head.pc;
   assign debug_wb_rf_wnum  = w_head.wnum;
   assign debug_wb_rf_wdata = w_head.wdata;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios then random traffic, checked against
// an array/queue model of the register file, HI/LO and retirement trace.
module tb_wb_regfile;
   import wb_regfile_pkg::*;

   localparam int TRACE_DEPTH = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                W_master_hilowrite, W_master_reg_wen, W_master_memtoReg;
   logic [4:0]          W_master_reg_waddr;
   logic [EXCEPT_W-1:0] W_master_except;
   logic [31:0]         W_master_pc, W_master_alu_res, W_master_mem_rdata;
   logic [63:0]         W_master_alu_out64;
   logic                W_slave_reg_wen;
   logic [4:0]          W_slave_reg_waddr;
   logic [EXCEPT_W-1:0] W_slave_except;
   logic [31:0]         W_slave_pc, W_slave_alu_res;
   logic [4:0]          raddr [4];
   logic [31:0]         rdata [4];
   logic [31:0]         hi_o, lo_o;
   logic                trace_stall;
   logic [31:0]         debug_wb_pc;
   logic [3:0]          debug_wb_rf_wen;
   logic [4:0]          debug_wb_rf_wnum;
   logic [31:0]         debug_wb_rf_wdata;

   always #5 clk = ~clk;

   wb_regfile #(.TRACE_DEPTH(TRACE_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .W_master_hilowrite(W_master_hilowrite), .W_master_reg_wen(W_master_reg_wen),
      .W_master_memtoReg(W_master_memtoReg), .W_master_reg_waddr(W_master_reg_waddr),
      .W_master_except(W_master_except), .W_master_pc(W_master_pc),
      .W_master_alu_res(W_master_alu_res), .W_master_mem_rdata(W_master_mem_rdata),
      .W_master_alu_out64(W_master_alu_out64),
      .W_slave_reg_wen(W_slave_reg_wen), .W_slave_reg_waddr(W_slave_reg_waddr),
      .W_slave_except(W_slave_except), .W_slave_pc(W_slave_pc),
      .W_slave_alu_res(W_slave_alu_res),
      .raddr0(raddr[0]), .raddr1(raddr[1]), .raddr2(raddr[2]), .raddr3(raddr[3]),
      .rdata0(rdata[0]), .rdata1(rdata[1]), .rdata2(rdata[2]), .rdata3(rdata[3]),
      .hi_o(hi_o), .lo_o(lo_o), .trace_stall(trace_stall),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0]  m_gpr [32];
   logic [63:0]  m_hilo;
   trace_entry_t m_trace [$];
   bit           exp_stall = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      W_master_hilowrite = 1'b0; W_master_reg_wen = 1'b0; W_master_memtoReg = 1'b0;
      W_master_reg_waddr = '0;   W_master_except = '0;    W_master_pc = '0;
      W_master_alu_res = '0;     W_master_mem_rdata = '0; W_master_alu_out64 = '0;
      W_slave_reg_wen = 1'b0;    W_slave_reg_waddr = '0;  W_slave_except = '0;
      W_slave_pc = '0;           W_slave_alu_res = '0;
   endtask

   // Youngest same-cycle writer wins, then the older one, then the stored value.
   function automatic logic [31:0] ref_read(input logic [4:0] a, input bit mc, input bit sc,
                                            input logic [31:0] mw);
      if (a == 5'd0)                             return 32'h0;
      if (sc && a == W_slave_reg_waddr)          return W_slave_alu_res;
      if (mc && a == W_master_reg_waddr)         return mw;
      return m_gpr[a];
   endfunction

   // One clock: entered at a negedge with inputs set, checks, advances the model.
   task automatic step(input bit chk_rd, input bit chk_tr);
      logic [31:0]  mw;
      logic [63:0]  eh;
      bit           mc, sc;
      trace_entry_t hd;
      if (exp_stall) begin
         W_master_pc = '0;
         W_slave_pc  = '0;
      end
      #1;
      mw = W_master_memtoReg ? W_master_mem_rdata : W_master_alu_res;
      mc = W_master_reg_wen && W_master_reg_waddr != 0 && W_master_except == 0;
      sc = W_slave_reg_wen && W_slave_reg_waddr != 0 && W_slave_except == 0
           && W_master_except == 0;
      eh = (W_master_hilowrite && W_master_except == 0) ? W_master_alu_out64 : m_hilo;
      if (chk_rd) begin
         for (int i = 0; i < 4; i++)
            chk($sformatf("rdata%0d[%0d]", i, raddr[i]), rdata[i], ref_read(raddr[i], mc, sc, mw));
         chk("hi_o", hi_o, eh[63:32]);
         chk("lo_o", lo_o, eh[31:0]);
      end
      if (chk_tr) begin
         hd = (m_trace.size() > 0) ? m_trace[0] : '0;
         chk("debug_wb_rf_wen", debug_wb_rf_wen, (m_trace.size() > 0) ? 4'hf : 4'h0);
         chk("debug_wb_pc", debug_wb_pc, hd.pc);
         chk("debug_wb_rf_wnum", debug_wb_rf_wnum, hd.wnum);
         chk("debug_wb_rf_wdata", debug_wb_rf_wdata, hd.wdata);
         chk("trace_stall", trace_stall, exp_stall);
      end
      if (rst) begin
         for (int i = 0; i < 32; i++) m_gpr[i] = '0;
         m_hilo = '0;
         m_trace.delete();
         exp_stall = 1'b0;
      end else begin
         if (mc) m_gpr[W_master_reg_waddr] = mw;
         if (sc) m_gpr[W_slave_reg_waddr] = W_slave_alu_res;
         m_hilo = eh;
         if (m_trace.size() > 0) m_trace.delete(0);
         if (mc && W_master_pc != 0)
            m_trace.push_back('{pc: W_master_pc, wnum: W_master_reg_waddr, wdata: mw});
         if (sc && W_slave_pc != 0)
            m_trace.push_back('{pc: W_slave_pc, wnum: W_slave_reg_waddr, wdata: W_slave_alu_res});
         exp_stall = (m_trace.size() > TRACE_DEPTH - 2);
      end
      @(negedge clk);
   endtask

   task automatic dual_commit(input logic [4:0] ma, input logic [4:0] sa, input logic [31:0] pc);
      clear_inputs();
      W_master_reg_wen = 1'b1; W_master_reg_waddr = ma; W_master_alu_res = pc ^ 32'h5a5a_0000;
      W_master_pc = pc;
      W_slave_reg_wen = 1'b1;  W_slave_reg_waddr = sa;  W_slave_alu_res = pc ^ 32'h0000_a5a5;
      W_slave_pc = pc + 32'd4;
   endtask

   task automatic drain();
      clear_inputs();
      for (int k = 0; k < 10 && m_trace.size() > 0; k++) step(1, 1);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) raddr[i] = '0;
      clear_inputs();
      rst = 1'b1;
      step(0, 0);
      step(0, 1);
      rst = 1'b0;

      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 4; i++) raddr[i] = 5'(k * 4 + i);
         step(1, 1);
      end

      clear_inputs();
      W_master_reg_wen = 1'b1; W_master_reg_waddr = 5'd5; W_master_alu_res = 32'h1234;
      W_master_pc = 32'h100; raddr[0] = 5'd5; raddr[1] = 5'd0;
      step(1, 1);
      clear_inputs();
      step(1, 1);

      clear_inputs();
      W_master_reg_wen = 1'b1; W_master_reg_waddr = 5'd8; W_master_alu_res = 32'hAAAA;
      W_master_pc = 32'h104;
      W_slave_reg_wen = 1'b1;  W_slave_reg_waddr = 5'd8;  W_slave_alu_res = 32'hBBBB;
      W_slave_pc = 32'h108;    raddr[0] = 5'd8;
      step(1, 1);
      clear_inputs();
      step(1, 1);
      step(1, 1);

      clear_inputs();
      W_master_hilowrite = 1'b1; W_master_alu_out64 = 64'h1111_2222_3333_4444;
      step(1, 1);
      clear_inputs();
      W_master_except = EXCEPT_W'(1); W_master_reg_wen = 1'b1; W_master_reg_waddr = 5'd10;
      W_master_alu_res = 32'hDEAD; W_master_pc = 32'h110;
      W_master_hilowrite = 1'b1; W_master_alu_out64 = 64'hFFFF_EEEE_DDDD_CCCC;
      W_slave_reg_wen = 1'b1; W_slave_reg_waddr = 5'd9; W_slave_alu_res = 32'hBEEF;
      W_slave_pc = 32'h114; raddr[0] = 5'd9; raddr[1] = 5'd10;
      step(1, 1);
      clear_inputs();
      step(1, 1);

      clear_inputs();
      W_master_reg_wen = 1'b1; W_master_reg_waddr = 5'd0; W_master_alu_res = 32'hFFFF_FFFF;
      W_master_pc = 32'h120; raddr[0] = 5'd0;
      step(1, 1);
      clear_inputs();
      step(1, 1);

      for (int k = 0; k < 4; k++) begin
         clear_inputs();
         for (int w = 0; w < 8 && exp_stall; w++) step(1, 1);
         dual_commit(5'(12 + 2 * k), 5'(13 + 2 * k), 32'h200 + 32'(16 * k));
         raddr[0] = 5'(12 + 2 * k); raddr[1] = 5'(13 + 2 * k);
         step(1, 1);
      end
      drain();

      dual_commit(5'd20, 5'd21, 32'h300);
      step(1, 1);
      dual_commit(5'd22, 5'd23, 32'h310);
      step(1, 1);
      dual_commit(5'd24, 5'd25, 32'h320);
      rst = 1'b1;
      step(0, 1);
      rst = 1'b0;
      clear_inputs();
      raddr[0] = 5'd5; raddr[1] = 5'd8; raddr[2] = 5'd20; raddr[3] = 5'd24;
      step(1, 1);

      for (int n = 0; n < 600; n++) begin
         W_master_hilowrite = ($urandom_range(0, 3) == 0);
         W_master_reg_wen   = ($urandom_range(0, 3) != 0);
         W_master_memtoReg  = $urandom_range(0, 1) == 1;
         W_master_reg_waddr = 5'($urandom_range(0, 7));
         W_master_except    = ($urandom_range(0, 7) == 0) ? EXCEPT_W'($urandom_range(1, 255)) : '0;
         W_master_pc        = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom() | 32'h1);
         W_master_alu_res   = $urandom();
         W_master_mem_rdata = $urandom();
         W_master_alu_out64 = {$urandom(), $urandom()};
         W_slave_reg_wen    = ($urandom_range(0, 3) != 0);
         W_slave_reg_waddr  = 5'($urandom_range(0, 7));
         W_slave_except     = ($urandom_range(0, 7) == 0) ? EXCEPT_W'($urandom_range(1, 255)) : '0;
         W_slave_pc         = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom() | 32'h1);
         W_slave_alu_res    = $urandom();
         for (int i = 0; i < 4; i++)
            raddr[i] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                   : 5'($urandom_range(0, 8));
         rst = ($urandom_range(0, 99) == 0);
         step(!rst, 1'b1);
      end
      rst = 1'b0;
      clear_inputs();
      step(1, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
